vga_sync_decoder: RTL and testbench



---
 rtl/vga_sync_decoder_pkg.sv | 15 +
 rtl/vga_sync_decoder_if.sv | 31 +++
 rtl/vga_sync_decoder_sync_edge_detect.sv | 35 +++
 rtl/vga_sync_decoder.sv | 153 +++++++++++++++
 tb/tb_vga_sync_decoder.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_sync_decoder_pkg.sv
// Shared VGA 640x480 timing definitions used by the generator, decoder and capture path.
package vga_timing_pkg;

  localparam int unsigned NomHTotal  = 800;
  localparam int unsigned NomHActive = 640;
  localparam int unsigned NomHSync   = 96;
  localparam int unsigned NomVTotal  = 525;
  localparam int unsigned NomVActive = 480;
  localparam int unsigned NomVSync   = 2;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} vga_state_e;

endpackage

// File: rtl/vga_sync_decoder_if.sv
// Strobe inputs and recovered-timing outputs of the VGA sync decoder.
interface vga_sync_decoder_if;
  import vga_timing_pkg::*;

  logic   VGA_HS;
  logic   VGA_VS;
  logic   VGA_BLANK_N;
  coord_t RxX;
  coord_t RxY;
  logic   Rx_Valid;
  logic   Line_Start;
  logic   Frame_Start;
  logic   Locked;
  logic   Err;
  logic   Err_Sticky;
  coord_t H_Meas;
  coord_t V_Meas;

  modport master (
    output VGA_HS, VGA_VS, VGA_BLANK_N,
    input  RxX, RxY, Rx_Valid, Line_Start, Frame_Start, Locked, Err, Err_Sticky,
    input  H_Meas, V_Meas
  );

  modport slave (
    input  VGA_HS, VGA_VS, VGA_BLANK_N,
    output RxX, RxY, Rx_Valid, Line_Start, Frame_Start, Locked, Err, Err_Sticky,
    output H_Meas, V_Meas
  );

endinterface

// File: rtl/vga_sync_decoder_sync_edge_detect.sv
// Two-stage input sampler with registered rise/fall pulses aligned to the sampled level.
module sync_edge_detect (
  input  logic Clk,
  input  logic Reset_n,
  input  logic i_d,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_rise;
  logic r_fall;

  // Pulses are registered one stage later so they line up with o_lvl.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= i_d;
      r_s2   <= r_s1;
      r_rise <= r_s1 & ~r_s2;
      r_fall <= ~r_s1 & r_s2;
    end
  end

  assign o_lvl  = r_s2;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: recovers pixel coordinates and verifies line/frame timing.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL  = NomHTotal,
  parameter int unsigned H_ACTIVE = NomHActive,
  parameter int unsigned H_SYNC   = NomHSync,
  parameter int unsigned V_TOTAL  = NomVTotal,
  parameter int unsigned V_ACTIVE = NomVActive,
  parameter int unsigned V_SYNC   = NomVSync
) (
  input  logic              Clk,
  input  logic              Reset_n,
  vga_sync_decoder_if.slave bus
);

  localparam coord_t HLast   = coord_t'(H_TOTAL - 1);
  localparam coord_t HActive = coord_t'(H_ACTIVE);
  localparam coord_t HSync   = coord_t'(H_SYNC);
  localparam coord_t VTotal  = coord_t'(V_TOTAL);
  localparam coord_t VActive = coord_t'(V_ACTIVE);
  localparam coord_t VSync   = coord_t'(V_SYNC);
  localparam coord_t CntMax  = '1;

  logic w_hs, w_hs_rise, w_hs_fall;
  logic w_vs, w_vs_rise, w_vs_fall;
  logic w_bl, w_bl_rise, w_bl_fall;
  logic w_unused;
  logic w_track, w_h_bad, w_v_bad, w_viol;

  vga_state_e r_state, w_state_d;
  coord_t r_hcnt, r_hsw, r_act, r_vcnt, r_vsw, r_aln;
  coord_t r_x, r_y, r_hmeas, r_vmeas;
  logic   r_first, r_hchk, r_valid, r_lstart, r_err, r_sticky;

  sync_edge_detect u_hs (
    .Clk(Clk), .Reset_n(Reset_n), .i_d(bus.VGA_HS),
    .o_lvl(w_hs), .o_rise(w_hs_rise), .o_fall(w_hs_fall)
  );
  sync_edge_detect u_vs (
    .Clk(Clk), .Reset_n(Reset_n), .i_d(bus.VGA_VS),
    .o_lvl(w_vs), .o_rise(w_vs_rise), .o_fall(w_vs_fall)
  );
  sync_edge_detect u_bl (
    .Clk(Clk), .Reset_n(Reset_n), .i_d(bus.VGA_BLANK_N),
    .o_lvl(w_bl), .o_rise(w_bl_rise), .o_fall(w_bl_fall)
  );

  assign w_unused = w_hs_rise ^ w_vs_rise ^ w_bl_fall;

  // Line checks are skipped until one full line has been seen since entering MEASURE.
  assign w_track = (r_state != SEARCH);
  assign w_h_bad = w_hs_fall & r_hchk &
                   ((r_hcnt != HLast) | (r_hsw != HSync) |
                    ((r_act != '0) & (r_act != HActive)));
  assign w_v_bad = w_vs_fall &
                   ((r_vcnt != VTotal) | (r_vsw != VSync) | (r_aln != VActive));
  assign w_viol  = w_track & (w_h_bad | w_v_bad | (r_hcnt == CntMax) | (w_bl & ~w_vs));

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      SEARCH:  if (w_vs_fall) w_state_d = MEASURE;
      MEASURE: begin
        if (w_viol)         w_state_d = SEARCH;
        else if (w_vs_fall) w_state_d = LOCKED;
      end
      LOCKED:  if (w_viol) w_state_d = SEARCH;
      default: w_state_d = SEARCH;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state  <= SEARCH;
      r_hcnt   <= '0;
      r_hsw    <= '0;
      r_act    <= '0;
      r_vcnt   <= '0;
      r_vsw    <= '0;
      r_aln    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_hmeas  <= '0;
      r_vmeas  <= '0;
      r_first  <= 1'b0;
      r_hchk   <= 1'b0;
      r_valid  <= 1'b0;
      r_lstart <= 1'b0;
      r_err    <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_hchk  <= (w_state_d != SEARCH) & w_track & (r_hchk | w_hs_fall);

      if (w_hs_fall) begin
        r_hmeas <= r_hcnt;
        r_hcnt  <= '0;
        r_hsw   <= coord_t'(1);
        r_act   <= coord_t'(w_bl);
      end else begin
        if (r_hcnt != CntMax) r_hcnt <= r_hcnt + 10'd1;
        if (!w_hs)            r_hsw  <= r_hsw + 10'd1;
        if (w_bl)             r_act  <= r_act + 10'd1;
      end

      // A coincident HS fall is checked above before vcnt restarts here.
      if (w_vs_fall) begin
        r_vmeas <= r_vcnt;
        r_vcnt  <= '0;
        r_vsw   <= coord_t'(w_hs_fall);
        r_aln   <= coord_t'(w_bl_rise);
      end else begin
        if (w_hs_fall)         r_vcnt <= r_vcnt + 10'd1;
        if (w_hs_fall && !w_vs) r_vsw <= r_vsw + 10'd1;
        if (w_bl_rise)         r_aln  <= r_aln + 10'd1;
      end

      if (!w_track && w_vs_fall) begin
        r_hcnt <= '0;
        r_hsw  <= '0;
        r_act  <= '0;
      end

      if (w_bl_rise) begin
        r_x <= '0;
        r_y <= r_first ? '0 : r_y + 10'd1;
      end else if (w_bl) begin
        r_x <= r_x + 10'd1;
      end

      if (w_vs_fall)      r_first <= 1'b1;
      else if (w_bl_rise) r_first <= 1'b0;

      r_valid  <= w_bl & w_track;
      r_lstart <= w_bl_rise & w_track;
      r_err    <= w_viol;
      r_sticky <= r_sticky | w_viol;
    end
  end

  assign bus.RxX         = r_x;
  assign bus.RxY         = r_y;
  assign bus.Rx_Valid    = r_valid;
  assign bus.Line_Start  = r_lstart;
  assign bus.Frame_Start = r_lstart & (r_y == '0);
  assign bus.Locked      = (r_state == LOCKED);
  assign bus.Err         = r_err;
  assign bus.Err_Sticky  = r_sticky;
  assign bus.H_Meas      = r_hmeas;
  assign bus.V_Meas      = r_vmeas;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench: a reduced-size VGA generator drives the decoder through lock and fault cases.
module tb_vga_sync_decoder;

  localparam int HT  = 100;
  localparam int HA  = 64;
  localparam int HS0 = 68;
  localparam int HSW = 12;
  localparam int VT  = 12;
  localparam int VA  = 8;
  localparam int VS0 = 9;
  localparam int VSW = 2;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_sync_decoder_if u_if ();

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC(HSW),
    .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC(VSW)
  ) u_dut (
    .Clk(clk),
    .Reset_n(rst_n),
    .bus(u_if)
  );

  int n_total = 0;
  int n_bad = 0;

  int gh = 0;
  int gv = 0;
  int short_line_v = -1;
  int hs_short_v = -1;
  logic hs_stuck = 1'b0;

  int edge_no = 0;
  int last_hs_fall = 0;
  logic prev_hs = 1'b1;
  logic prev_vs = 1'b1;
  logic vs_fell = 1'b0;

  logic hb [3];
  int hh [3];
  int hv [3];
  logic chk_coord = 1'b0;
  int valid_cnt = 0;
  int fs_cnt = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One pixel clock: drive generator pins, clock, record history, advance the generator.
  task automatic step();
    int hs_len;
    int line_len;
    logic hs_p, vs_p, bl_p;
    hs_len = (gv == hs_short_v) ? HSW - 1 : HSW;
    hs_p = hs_stuck || !(gh >= HS0 && gh < HS0 + hs_len);
    vs_p = !(gv >= VS0 && gv < VS0 + VSW);
    bl_p = (gh < HA) && (gv < VA);
    u_if.VGA_HS = hs_p;
    u_if.VGA_VS = vs_p;
    u_if.VGA_BLANK_N = bl_p;
    @(posedge clk);
    #1;
    edge_no++;
    if (prev_vs && !vs_p) vs_fell = 1'b1;
    if (prev_hs && !hs_p) last_hs_fall = edge_no;
    prev_vs = vs_p;
    prev_hs = hs_p;
    hb[2] = hb[1]; hb[1] = hb[0]; hb[0] = bl_p;
    hh[2] = hh[1]; hh[1] = hh[0]; hh[0] = gh;
    hv[2] = hv[1]; hv[1] = hv[0]; hv[0] = gv;
    line_len = (gv == short_line_v) ? HT - 1 : HT;
    if (gh >= line_len - 1) begin
      gh = 0;
      if (gv == short_line_v) short_line_v = -1;
      if (gv == hs_short_v) hs_short_v = -1;
      gv = (gv == VT - 1) ? 0 : gv + 1;
    end else begin
      gh++;
    end
    if (chk_coord) begin
      check_eq("rx_valid", int'(u_if.Rx_Valid), int'(hb[2]));
      if (hb[2]) begin
        check_eq("rx_x", int'(u_if.RxX), hh[2]);
        check_eq("rx_y", int'(u_if.RxY), hv[2]);
      end
      check_eq("line_start", int'(u_if.Line_Start), int'(hb[2] && hh[2] == 0));
      check_eq("frame_start", int'(u_if.Frame_Start),
               int'(hb[2] && hh[2] == 0 && hv[2] == 0));
      valid_cnt += int'(u_if.Rx_Valid);
      fs_cnt += int'(u_if.Frame_Start);
    end
  endtask

  task automatic wait_vs_fall();
    int n;
    n = 0;
    vs_fell = 1'b0;
    while (!vs_fell && n < 3 * FRAME) begin
      step();
      n++;
    end
    check_eq("vs_fall_seen", int'(vs_fell), 1);
  endtask

  // Steps two edges past the VS fall and checks the resulting lock state.
  task automatic check_lock_after_vs(input string tag, input int exp_locked);
    wait_vs_fall();
    step();
    if (exp_locked == 1) check_eq({tag, "_pre"}, int'(u_if.Locked), 0);
    step();
    check_eq(tag, int'(u_if.Locked), exp_locked);
  endtask

  task automatic wait_err(input int budget, output int at_edge);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      step();
      n++;
      seen = u_if.Err;
    end
    check_eq("err_seen", int'(seen), 1);
    at_edge = edge_no;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rxx"}, int'(u_if.RxX), 0);
    check_eq({tag, "_rxy"}, int'(u_if.RxY), 0);
    check_eq({tag, "_valid"}, int'(u_if.Rx_Valid), 0);
    check_eq({tag, "_lstart"}, int'(u_if.Line_Start), 0);
    check_eq({tag, "_fstart"}, int'(u_if.Frame_Start), 0);
    check_eq({tag, "_locked"}, int'(u_if.Locked), 0);
    check_eq({tag, "_err"}, int'(u_if.Err), 0);
    check_eq({tag, "_sticky"}, int'(u_if.Err_Sticky), 0);
    check_eq({tag, "_hmeas"}, int'(u_if.H_Meas), 0);
    check_eq({tag, "_vmeas"}, int'(u_if.V_Meas), 0);
  endtask

  initial begin
    int e;
    for (int i = 0; i < 3; i++) begin
      hb[i] = 1'b0;
      hh[i] = 0;
      hv[i] = 0;
    end

    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1;

    // First VS fall enters MEASURE, second locks three edges after the pin fall
    check_lock_after_vs("first_vs", 0);
    check_lock_after_vs("lock", 1);
    check_eq("h_meas", int'(u_if.H_Meas), HT - 1);
    check_eq("v_meas", int'(u_if.V_Meas), VT);
    check_eq("sticky_clean", int'(u_if.Err_Sticky), 0);

    // Coordinate tracking over one full frame period
    chk_coord = 1'b1;
    repeat (FRAME) step();
    chk_coord = 1'b0;
    check_eq("valid_per_frame", valid_cnt, HA * VA);
    check_eq("fstart_per_frame", fs_cnt, 1);
    check_eq("still_locked", int'(u_if.Locked), 1);

    // Short line while locked
    short_line_v = 5;
    wait_err(2 * FRAME, e);
    check_eq("short_err_latency", e - last_hs_fall, 2);
    check_eq("short_locked", int'(u_if.Locked), 0);
    check_eq("short_sticky", int'(u_if.Err_Sticky), 1);
    step();
    check_eq("err_one_cycle", int'(u_if.Err), 0);

    // HS pulse one clock short during MEASURE
    check_lock_after_vs("measure_entry", 0);
    hs_short_v = 3;
    wait_err(2 * FRAME, e);
    check_eq("hsw_err_latency", e - last_hs_fall, 2);
    check_eq("hsw_locked", int'(u_if.Locked), 0);
    check_lock_after_vs("hsw_no_lock", 0);
    check_lock_after_vs("relock", 1);
    check_eq("relock_sticky", int'(u_if.Err_Sticky), 1);

    // HS stuck high while locked: error when hcnt saturates
    wait_vs_fall();
    repeat (80) step();
    hs_stuck = 1'b1;
    wait_err(1100, e);
    check_eq("stuck_err_latency", e - last_hs_fall, 1026);
    check_eq("stuck_locked", int'(u_if.Locked), 0);
    hs_stuck = 1'b0;
    check_lock_after_vs("stuck_measure", 0);
    check_lock_after_vs("stuck_relock", 1);

    // Reset mid-frame
    while (!(gv == 5 && gh == 30)) step();
    rst_n = 1'b0;
    step();
    check_all_zero("midreset");
    rst_n = 1'b1;
    check_lock_after_vs("midreset_measure", 0);
    check_lock_after_vs("midreset_relock", 1);
    check_eq("midreset_sticky", int'(u_if.Err_Sticky), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
